// File: rtl/id_stage_if.sv
// id_stage_if: IF/regfile/EX-side signals of the decode stage, grouped for id_stage_reg
interface id_stage_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int ALUOP_W = 4
);
    logic [31:0]        inst_i;
    logic [XLEN-1:0]    inst_addr_i;
    logic               inst_valid_i;
    logic               inst_ready_o;
    logic [RADDR_W-1:0] rs1_addr_o;
    logic [RADDR_W-1:0] rs2_addr_o;
    logic [XLEN-1:0]    rs1_data_i;
    logic [XLEN-1:0]    rs2_data_i;
    logic               flush_i;
    logic               valid_o;
    logic               ready_i;
    logic [31:0]        inst_o;
    logic [XLEN-1:0]    inst_addr_o;
    logic [XLEN-1:0]    op_num1_o;
    logic [XLEN-1:0]    op_num2_o;
    logic [RADDR_W-1:0] rd_addr_o;
    logic               reg_wen_o;
    logic [ALUOP_W-1:0] alu_op_o;
    logic               illegal_o;

    modport master (
        output inst_i, inst_addr_i, inst_valid_i, rs1_data_i, rs2_data_i, flush_i, ready_i,
        input  inst_ready_o, rs1_addr_o, rs2_addr_o, valid_o, inst_o, inst_addr_o,
               op_num1_o, op_num2_o, rd_addr_o, reg_wen_o, alu_op_o, illegal_o
    );

    modport slave (
        input  inst_i, inst_addr_i, inst_valid_i, rs1_data_i, rs2_data_i, flush_i, ready_i,
        output inst_ready_o, rs1_addr_o, rs2_addr_o, valid_o, inst_o, inst_addr_o,
               op_num1_o, op_num2_o, rd_addr_o, reg_wen_o, alu_op_o, illegal_o
    );
endinterface

// File: rtl/id_stage_reg.sv
// id_stage_reg: registered RV32I/RV64I integer decode stage (OP-IMM, OP, LUI, AUIPC)
// with valid/ready handshakes, flush, and illegal-encoding flagging.
module id_stage_reg #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int ALUOP_W = 4
) (
    input logic        clk,
    input logic        rst,
    id_stage_if.slave  bus
);
    localparam logic [ALUOP_W-1:0] NOP  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ADD  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] SUB  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] SLL  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] SLT  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] SLTU = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] XOR  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] SRL  = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] SRA  = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] OR   = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] AND  = ALUOP_W'(10);

    function automatic logic [ALUOP_W-1:0] base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  base_op = ADD;
            3'b001:  base_op = SLL;
            3'b010:  base_op = SLT;
            3'b011:  base_op = SLTU;
            3'b100:  base_op = XOR;
            3'b101:  base_op = SRL;
            3'b110:  base_op = OR;
            default: base_op = AND;
        endcase
    endfunction

    logic [31:0]      inst;
    logic [6:0]       opc, f7;
    logic [2:0]       f3;
    logic [XLEN-1:0]  imm_i, imm_u, shamt;
    logic             sh_l, sh_a;
    logic             legal, use1, use2;
    logic [ALUOP_W-1:0] op;
    logic [XLEN-1:0]  a, b;
    logic             accept;

    assign inst  = bus.inst_i;
    assign opc   = inst[6:0];
    assign f3    = inst[14:12];
    assign f7    = inst[31:25];
    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    // RV64 shifts borrow f7[0] as the sixth shamt bit, so only f7[6:1] qualifies the op
    assign shamt = XLEN == 32 ? XLEN'(inst[24:20]) : XLEN'(inst[25:20]);
    assign sh_l  = XLEN == 32 ? f7 == 7'h00 : inst[31:26] == 6'h00;
    assign sh_a  = XLEN == 32 ? f7 == 7'h20 : inst[31:26] == 6'h10;

    always_comb begin
        legal = 1'b0;
        op    = NOP;
        a     = '0;
        b     = '0;
        use1  = 1'b0;
        use2  = 1'b0;
        case (opc)
            7'b0010011: begin
                legal = f3 == 3'b001 ? sh_l : f3 == 3'b101 ? (sh_l | sh_a) : 1'b1;
                op    = (f3 == 3'b101 && sh_a) ? SRA : base_op(f3);
                a     = bus.rs1_data_i;
                b     = f3[1:0] == 2'b01 ? shamt : imm_i;
                use1  = 1'b1;
            end
            7'b0110011: begin
                legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
                op    = f7 == 7'h20 ? (f3 == 3'b000 ? SUB : SRA) : base_op(f3);
                a     = bus.rs1_data_i;
                b     = bus.rs2_data_i;
                use1  = 1'b1;
                use2  = 1'b1;
            end
            7'b0110111: begin
                legal = 1'b1;
                op    = ADD;
                b     = imm_u;
            end
            7'b0010111: begin
                legal = 1'b1;
                op    = ADD;
                a     = bus.inst_addr_i;
                b     = imm_u;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            op   = NOP;
            a    = '0;
            b    = '0;
            use1 = 1'b0;
            use2 = 1'b0;
        end
    end

    assign bus.rs1_addr_o   = (bus.inst_valid_i && use1) ? RADDR_W'(inst[19:15]) : '0;
    assign bus.rs2_addr_o   = (bus.inst_valid_i && use2) ? RADDR_W'(inst[24:20]) : '0;
    assign bus.inst_ready_o = !bus.valid_o || bus.ready_i;
    assign accept           = bus.inst_valid_i && bus.inst_ready_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.valid_o     <= 1'b0;
            bus.inst_o      <= '0;
            bus.inst_addr_o <= '0;
            bus.op_num1_o   <= '0;
            bus.op_num2_o   <= '0;
            bus.rd_addr_o   <= '0;
            bus.reg_wen_o   <= 1'b0;
            bus.alu_op_o    <= NOP;
            bus.illegal_o   <= 1'b0;
        end else if (bus.flush_i) begin
            bus.valid_o <= 1'b0;
        end else if (bus.inst_ready_o) begin
            bus.valid_o <= bus.inst_valid_i;
            if (accept) begin
                bus.inst_o      <= inst;
                bus.inst_addr_o <= bus.inst_addr_i;
                bus.op_num1_o   <= a;
                bus.op_num2_o   <= b;
                bus.rd_addr_o   <= legal ? RADDR_W'(inst[11:7]) : '0;
                bus.reg_wen_o   <= legal && inst[11:7] != 5'd0;
                bus.alu_op_o    <= op;
                bus.illegal_o   <= !legal;
            end
        end
    end
endmodule

// File: tb/tb_id_stage_reg.sv
// tb_id_stage_reg: directed vectors against hand-computed decode results for id_stage_reg
module tb_id_stage_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    id_stage_if #(.XLEN(32), .RADDR_W(5), .ALUOP_W(4)) bus ();
    id_stage_reg #(.XLEN(32), .RADDR_W(5), .ALUOP_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic vld,
                         input logic [31:0] r1, input logic [31:0] r2, input logic rdy, input logic fl);
        bus.inst_i       = inst;
        bus.inst_addr_i  = pc;
        bus.inst_valid_i = vld;
        bus.rs1_data_i   = r1;
        bus.rs2_data_i   = r2;
        bus.ready_i      = rdy;
        bus.flush_i      = fl;
        #1;
    endtask

    task automatic out_chk(input string tag, input logic v, input logic [31:0] o1, input logic [31:0] o2,
                           input logic [4:0] rd, input logic wen, input logic [3:0] alu, input logic ill);
        check({tag, ".valid"}, 64'(bus.valid_o), 64'(v));
        check({tag, ".op1"}, 64'(bus.op_num1_o), 64'(o1));
        check({tag, ".op2"}, 64'(bus.op_num2_o), 64'(o2));
        check({tag, ".rd"}, 64'(bus.rd_addr_o), 64'(rd));
        check({tag, ".wen"}, 64'(bus.reg_wen_o), 64'(wen));
        check({tag, ".alu"}, 64'(bus.alu_op_o), 64'(alu));
        check({tag, ".ill"}, 64'(bus.illegal_o), 64'(ill));
    endtask

    initial begin
        drive(32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        out_chk("rst", 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 4'd0, 1'b0);
        check("rst.inst", 64'(bus.inst_o), 64'h0);
        check("rst.rdy", 64'(bus.inst_ready_o), 64'h1);
        check("idle.rs1a", 64'(bus.rs1_addr_o), 64'h0);
        rst = 1'b0;

        // addi x1,x0,-1
        @(negedge clk);
        drive(32'hFFF00093, 32'h40, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
        check("addi.rs2a", 64'(bus.rs2_addr_o), 64'h0);
        @(negedge clk);
        out_chk("addi", 1'b1, 32'h0, 32'hFFFFFFFF, 5'd1, 1'b1, 4'd1, 1'b0);
        check("addi.inst", 64'(bus.inst_o), 64'hFFF00093);
        check("addi.pc", 64'(bus.inst_addr_o), 64'h40);

        // add x3,x1,x2 accepted, then held through a 3-cycle stall
        drive(32'h002081B3, 32'h44, 1'b1, 32'd5, 32'd7, 1'b1, 1'b0);
        check("add.rs1a", 64'(bus.rs1_addr_o), 64'd1);
        check("add.rs2a", 64'(bus.rs2_addr_o), 64'd2);
        @(negedge clk);
        drive(32'h40520233, 32'h48, 1'b1, 32'd11, 32'd13, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("stall.rdy", 64'(bus.inst_ready_o), 64'h0);
            out_chk("stall", 1'b1, 32'd5, 32'd7, 5'd3, 1'b1, 4'd1, 1'b0);
            @(negedge clk);
        end
        drive(32'h40520233, 32'h48, 1'b1, 32'd11, 32'd13, 1'b1, 1'b0);
        @(negedge clk);
        out_chk("sub", 1'b1, 32'd11, 32'd13, 5'd4, 1'b1, 4'd2, 1'b0);

        // srai x6,x6,3 -- operand captured at accept, later regfile value ignored
        drive(32'h40335313, 32'h4C, 1'b1, 32'hF0, 32'h99, 1'b1, 1'b0);
        check("srai.rs1a", 64'(bus.rs1_addr_o), 64'd6);
        check("srai.rs2a", 64'(bus.rs2_addr_o), 64'd0);
        @(negedge clk);
        drive(32'h00000013, 32'h50, 1'b1, 32'h1234, 32'h0, 1'b1, 1'b0);
        out_chk("srai", 1'b1, 32'hF0, 32'd3, 5'd6, 1'b1, 4'd8, 1'b0);

        // addi x0,x0,0 : legal but no writeback
        @(negedge clk);
        out_chk("nop", 1'b1, 32'h1234, 32'h0, 5'd0, 1'b0, 4'd1, 1'b0);

        // illegal opcode 0x7F (non-zero rs1 field must not leak)
        drive(32'h0020807F, 32'h54, 1'b1, 32'h55, 32'h66, 1'b1, 1'b0);
        check("ill7f.rs1a", 64'(bus.rs1_addr_o), 64'h0);
        @(negedge clk);
        out_chk("ill7f", 1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 4'd0, 1'b1);

        // OP with f7=0000001
        drive(32'h022081B3, 32'h58, 1'b1, 32'h55, 32'h66, 1'b1, 1'b0);
        check("illf7.rs2a", 64'(bus.rs2_addr_o), 64'h0);
        @(negedge clk);
        out_chk("illf7", 1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 4'd0, 1'b1);

        // drained with no new input -> valid drops
        drive(32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        check("drain.valid", 64'(bus.valid_o), 64'h0);

        // hold an add, then flush while a new instruction is offered
        drive(32'h002081B3, 32'h60, 1'b1, 32'd1, 32'd2, 1'b0, 1'b0);
        @(negedge clk);
        check("hold.valid", 64'(bus.valid_o), 64'h1);
        drive(32'hFFF00093, 32'h64, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        check("flush.valid", 64'(bus.valid_o), 64'h0);
        check("flush.op2", 64'(bus.op_num2_o), 64'd2);

        // lui x7,0x80000 then auipc x8,0x80000, both at PC 0x100
        drive(32'h800003B7, 32'h100, 1'b1, 32'hAA, 32'hBB, 1'b1, 1'b0);
        check("lui.rs1a", 64'(bus.rs1_addr_o), 64'h0);
        @(negedge clk);
        out_chk("lui", 1'b1, 32'h0, 32'h80000000, 5'd7, 1'b1, 4'd1, 1'b0);
        drive(32'h80000417, 32'h100, 1'b1, 32'hAA, 32'hBB, 1'b1, 1'b0);
        @(negedge clk);
        out_chk("auipc", 1'b1, 32'h100, 32'h80000000, 5'd8, 1'b1, 4'd1, 1'b0);

        // async reset during a stall clears outputs without a clock edge
        drive(32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        out_chk("arst", 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 4'd0, 1'b0);
        check("arst.pc", 64'(bus.inst_addr_o), 64'h0);
        rst = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
